// File: rtl/cmac_rx_pkt_checker.sv
// rtl/cmac_rx_pkt_checker.sv - CMAC RX packet checker: length/seq/payload checks, packet and throughput counters (optional PKT_CHECK_PAYLOAD_EN)
module cmac_rx_pkt_checker #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_axis_tvalid,
    output logic                  rx_axis_tready,
    input  logic [DATA_WIDTH-1:0] rx_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] rx_axis_tkeep,
    input  logic                  rx_axis_tlast,
    input  logic                  rx_axis_tuser,
    input  logic                  recv_en,
    input  logic [15:0]           pkt_size,
    output logic [CNT_WIDTH-1:0]  recv_pkt_cnt,
    output logic [CNT_WIDTH-1:0]  err_pkt_cnt,
    output logic [CNT_WIDTH-1:0]  total_beat_cnt,
    output logic [CNT_WIDTH-1:0]  perf_beat_cnt,
    output logic [CNT_WIDTH-1:0]  perf_cycle_cnt,
    output logic                  perf_cycle_full,
    output logic                  first_pkt_seen,
    output logic                  err_pulse
);

    localparam int LANES = DATA_WIDTH / 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic        beat;
    logic        first_beat;
    logic        chk_beat;
    logic [31:0] keep_ones;
    logic        keep_contig;
    logic [31:0] byte_cnt;
    logic [31:0] byte_now;
    logic [11:0] beat_idx;
    logic [11:0] beat_idx_now;
    logic [15:0] rx_seq;
    logic [15:0] seq_now;
    logic [15:0] exp_seq;
    logic        err_acc;
    logic        err_beat;
    logic        err_run;
    logic        pkt_err;
    logic        payload_err;

    assign beat       = rx_axis_tvalid & rx_axis_tready;
    assign first_beat = (state == IDLE);
    // recv_en only matters on the first beat; later beats follow the latched state
    assign chk_beat   = beat & ((first_beat & recv_en) | (state == RECV));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (beat && !rx_axis_tlast) begin
                    state_nxt = recv_en ? RECV : DROP;
                end
            end
            RECV, DROP: begin
                if (beat && rx_axis_tlast) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        keep_ones = 32'd0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            keep_ones = keep_ones + 32'(rx_axis_tkeep[i]);
        end
    end

    // contiguous from bit 0 means tkeep+1 is a power of two
    assign keep_contig = (rx_axis_tkeep != '0) &&
                         ((rx_axis_tkeep & (rx_axis_tkeep + KEEP_WIDTH'(1))) == '0);

    assign byte_now     = (first_beat ? 32'd0 : byte_cnt) + keep_ones;
    assign beat_idx_now = first_beat ? 12'd0 : beat_idx;
    assign seq_now      = first_beat ? rx_axis_tdata[31:16] : rx_seq;

`ifdef PKT_CHECK_PAYLOAD_EN
    always_comb begin
        payload_err = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            if ((&rx_axis_tkeep[4*k +: 4]) &&
                (rx_axis_tdata[32*k +: 32] != {seq_now, beat_idx_now, k[3:0]})) begin
                payload_err = 1'b1;
            end
        end
    end
`else
    logic unused_tdata;
    assign unused_tdata = ^rx_axis_tdata;
    assign payload_err  = 1'b0;
`endif

    assign err_beat = rx_axis_tuser
                    | (!rx_axis_tlast && !(&rx_axis_tkeep))
                    | (rx_axis_tlast && !keep_contig)
                    | payload_err;
    assign err_run  = (first_beat ? 1'b0 : err_acc) | err_beat;
    assign pkt_err  = err_run
                    | (byte_now != {16'd0, pkt_size})
                    | (seq_now != exp_seq);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_axis_tready <= 1'b0;
            byte_cnt       <= 32'd0;
            beat_idx       <= 12'd0;
            rx_seq         <= 16'd0;
            exp_seq        <= 16'd0;
            err_acc        <= 1'b0;
            recv_pkt_cnt   <= '0;
            err_pkt_cnt    <= '0;
            total_beat_cnt <= '0;
            err_pulse      <= 1'b0;
        end else begin
            rx_axis_tready <= 1'b1;
            err_pulse      <= 1'b0;
            if (chk_beat) begin
                byte_cnt       <= byte_now;
                beat_idx       <= beat_idx_now + 12'd1;
                rx_seq         <= seq_now;
                err_acc        <= err_run;
                total_beat_cnt <= total_beat_cnt + CNT_WIDTH'(1);
                if (rx_axis_tlast) begin
                    recv_pkt_cnt <= recv_pkt_cnt + CNT_WIDTH'(1);
                    // resync to whatever arrived so one gap flags only one packet
                    exp_seq      <= seq_now + 16'd1;
                    if (pkt_err) begin
                        err_pkt_cnt <= err_pkt_cnt + CNT_WIDTH'(1);
                        err_pulse   <= 1'b1;
                    end
                end
            end
        end
    end

    // perf window: opens on the first checked beat, freezes once the cycle count saturates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_pkt_seen  <= 1'b0;
            perf_cycle_full <= 1'b0;
            perf_cycle_cnt  <= '0;
            perf_beat_cnt   <= '0;
        end else if (!first_pkt_seen) begin
            if (chk_beat) begin
                first_pkt_seen <= 1'b1;
                perf_cycle_cnt <= CNT_WIDTH'(1);
                perf_beat_cnt  <= CNT_WIDTH'(1);
            end
        end else if (!perf_cycle_full) begin
            perf_cycle_cnt <= perf_cycle_cnt + CNT_WIDTH'(1);
            if (chk_beat) begin
                perf_beat_cnt <= perf_beat_cnt + CNT_WIDTH'(1);
            end
            if ((perf_cycle_cnt + CNT_WIDTH'(1)) == {CNT_WIDTH{1'b1}}) begin
                perf_cycle_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cmac_rx_pkt_checker.sv
// tb/tb_cmac_rx_pkt_checker.sv - randomized self-checking bench for cmac_rx_pkt_checker
module tb_cmac_rx_pkt_checker;

    localparam int DW = 512;
    localparam int KW = 64;
    localparam int CW = 32;

`ifdef PKT_CHECK_PAYLOAD_EN
    localparam bit PAYLOAD_ON = 1'b1;
`else
    localparam bit PAYLOAD_ON = 1'b0;
`endif

    // fault kinds injected into a packet
    localparam int F_NONE = 0, F_SIZE = 1, F_TUSER = 2, F_MIDKEEP = 3,
                   F_PAY0 = 4, F_LASTSHIFT = 5, F_LASTF0 = 6, F_LANE7B1 = 7;

    logic          clk;
    logic          rst_n;
    logic          rx_axis_tvalid;
    logic          rx_axis_tready;
    logic [DW-1:0] rx_axis_tdata;
    logic [KW-1:0] rx_axis_tkeep;
    logic          rx_axis_tlast;
    logic          rx_axis_tuser;
    logic          recv_en;
    logic [15:0]   pkt_size;
    logic [CW-1:0] recv_pkt_cnt;
    logic [CW-1:0] err_pkt_cnt;
    logic [CW-1:0] total_beat_cnt;
    logic [CW-1:0] perf_beat_cnt;
    logic [CW-1:0] perf_cycle_cnt;
    logic          perf_cycle_full;
    logic          first_pkt_seen;
    logic          err_pulse;

    cmac_rx_pkt_checker #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .CNT_WIDTH(CW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rx_axis_tvalid  (rx_axis_tvalid),
        .rx_axis_tready  (rx_axis_tready),
        .rx_axis_tdata   (rx_axis_tdata),
        .rx_axis_tkeep   (rx_axis_tkeep),
        .rx_axis_tlast   (rx_axis_tlast),
        .rx_axis_tuser   (rx_axis_tuser),
        .recv_en         (recv_en),
        .pkt_size        (pkt_size),
        .recv_pkt_cnt    (recv_pkt_cnt),
        .err_pkt_cnt     (err_pkt_cnt),
        .total_beat_cnt  (total_beat_cnt),
        .perf_beat_cnt   (perf_beat_cnt),
        .perf_cycle_cnt  (perf_cycle_cnt),
        .perf_cycle_full (perf_cycle_full),
        .first_pkt_seen  (first_pkt_seen),
        .err_pulse       (err_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          edge_cnt = 0;
    int          pulse_cnt = 0;
    int unsigned m_recv, m_err, m_total, m_pbeat;
    logic [15:0] m_exp_seq;
    bit          m_seen;
    int          first_edge;

    always @(negedge clk) begin
        if (rst_n && err_pulse) pulse_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edge_cnt++;
        #1;
    endtask

    function automatic logic [31:0] pat(input logic [15:0] p, input int b, input int k);
        logic [11:0] bb;
        logic [3:0]  kk;
        bb = b[11:0];
        kk = k[3:0];
        return {p, bb, kk};
    endfunction

    task automatic model_clear();
        m_recv = 0; m_err = 0; m_total = 0; m_pbeat = 0;
        m_exp_seq = 16'd0; m_seen = 1'b0; first_edge = 0; pulse_cnt = 0;
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        rx_axis_tvalid = 1'b0;
        rx_axis_tlast = 1'b0;
        rx_axis_tuser = 1'b0;
        #1;
        check("rst_tready", rx_axis_tready, 0);
        check("rst_recv", recv_pkt_cnt, 0);
        check("rst_perf", perf_cycle_cnt, 0);
        for (int i = 0; i < cycles; i++) tick();
        rst_n = 1'b1;
        model_clear();
        tick();
        check("tready_up", rx_axis_tready, 1);
    endtask

    task automatic check_counters(input string tag);
        logic [CW-1:0] exp_cyc;
        exp_cyc = m_seen ? CW'(edge_cnt - first_edge + 1) : '0;
        check({tag, "_recv"}, recv_pkt_cnt, m_recv);
        check({tag, "_err"}, err_pkt_cnt, m_err);
        check({tag, "_total"}, total_beat_cnt, m_total);
        check({tag, "_pbeat"}, perf_beat_cnt, m_pbeat);
        check({tag, "_pcyc"}, perf_cycle_cnt, exp_cyc);
        check({tag, "_seen"}, first_pkt_seen, m_seen);
        check({tag, "_full"}, perf_cycle_full, 0);
    endtask

    // sends one packet; stop_at >= 0 abandons it after that many beats
    task automatic send_pkt(input logic [15:0] seq, input int nbytes, input bit en,
                            input int fault, input int gap_pct, input int stop_at);
        int            nb, rem, fbeat;
        bit            e;
        logic [KW-1:0] lastmask, kp;
        logic [DW-1:0] d;
        logic [15:0]   size_in;
        nb = (nbytes + 63) / 64;
        rem = nbytes - 64 * (nb - 1);
        fbeat = $urandom_range(0, nb - 1);
        lastmask = '0;
        for (int i = 0; i < rem; i++) lastmask[i] = 1'b1;
        size_in = (fault == F_SIZE) ? 16'(nbytes + 1) : 16'(nbytes);
        e = (seq != m_exp_seq) || fault == F_SIZE || fault == F_TUSER ||
            fault == F_MIDKEEP || fault == F_LASTSHIFT || fault == F_LASTF0 ||
            ((fault == F_PAY0 || fault == F_LANE7B1) && PAYLOAD_ON);
        for (int b = 0; b < nb; b++) begin
            if (stop_at >= 0 && b >= stop_at) return;
            while (($urandom % 100) < gap_pct) begin
                rx_axis_tvalid = 1'b0;
                rx_axis_tlast = 1'($urandom);
                rx_axis_tdata = {16{$urandom}};
                tick();
            end
            for (int k = 0; k < 16; k++) d[32*k +: 32] = pat(seq, b, k);
            kp = (b == nb - 1) ? lastmask : '1;
            if (fault == F_MIDKEEP && b == 0) kp[KW-1] = 1'b0;
            if (fault == F_LASTSHIFT && b == nb - 1) kp = kp << 1;
            if (fault == F_LASTF0 && b == nb - 1) kp = KW'(8'hF0);
            if (fault == F_PAY0 && b == 0) d[0] = ~d[0];
            if (fault == F_LANE7B1 && b == 1) d[32*7 + 5] = ~d[32*7 + 5];
            rx_axis_tvalid = 1'b1;
            rx_axis_tdata = d;
            rx_axis_tkeep = kp;
            rx_axis_tlast = (b == nb - 1);
            rx_axis_tuser = (fault == F_TUSER && b == fbeat);
            recv_en = (b == 0) ? en : 1'($urandom);
            pkt_size = (b == nb - 1) ? size_in : 16'($urandom);
            tick();
            if (en) begin
                m_total++;
                if (!m_seen) begin
                    m_seen = 1'b1;
                    first_edge = edge_cnt;
                end
                m_pbeat++;
            end
        end
        rx_axis_tvalid = 1'b0;
        rx_axis_tlast = 1'b0;
        rx_axis_tuser = 1'b0;
        if (en) begin
            m_recv++;
            if (e) m_err++;
            m_exp_seq = seq + 16'd1;
        end
        check("err_pulse", err_pulse, e & en);
    endtask

    initial begin
        logic [15:0] seqs [4];
        int          r, sz, flt, nb;
        logic [15:0] sq;
        bit          en;
        rst_n = 1'b0;
        rx_axis_tvalid = 1'b0;
        rx_axis_tdata = '0;
        rx_axis_tkeep = '0;
        rx_axis_tlast = 1'b0;
        rx_axis_tuser = 1'b0;
        recv_en = 1'b0;
        pkt_size = 16'd0;
        model_clear();

        // ten clean 4-beat packets back-to-back
        do_reset(2);
        for (int s = 0; s < 10; s++) send_pkt(16'(s), 256, 1'b1, F_NONE, 0, -1);
        check_counters("b2b");
        check("b2b_recv10", recv_pkt_cnt, 10);
        check("b2b_total40", total_beat_cnt, 40);
        check("b2b_pbeat40", perf_beat_cnt, 40);

        // partial last beat: contiguous ok, 0xF0 flagged
        do_reset(2);
        send_pkt(16'd0, 100, 1'b1, F_NONE, 0, -1);
        send_pkt(16'd1, 100, 1'b1, F_LASTF0, 0, -1);
        tick();
        check_counters("keep");
        check("keep_err1", err_pkt_cnt, 1);
        check("keep_pulses", pulse_cnt, 1);

        // sequence gap flags only the first out-of-order packet
        do_reset(2);
        seqs = '{16'd0, 16'd1, 16'd5, 16'd6};
        foreach (seqs[i]) send_pkt(seqs[i], 192, 1'b1, F_NONE, 0, -1);
        check_counters("seq");
        check("seq_err1", err_pkt_cnt, 1);

        // single-bit payload corruption in lane 7 of beat 1
        do_reset(2);
        send_pkt(16'd0, 256, 1'b1, F_LANE7B1, 0, -1);
        check_counters("lane7");
        check("lane7_err", err_pkt_cnt, PAYLOAD_ON ? 1 : 0);

        // disabled packets are dropped; tuser flags the first counted one
        do_reset(2);
        for (int i = 0; i < 3; i++) send_pkt(16'(i + 3), 130, 1'b0, F_NONE, 10, -1);
        check("dis_seen", first_pkt_seen, 0);
        check("dis_recv", recv_pkt_cnt, 0);
        send_pkt(16'd0, 130, 1'b1, F_TUSER, 10, -1);
        check_counters("dis");
        check("dis_err1", err_pkt_cnt, 1);

        // reset in the middle of a packet, then restart from seq 0
        do_reset(2);
        send_pkt(16'd0, 256, 1'b1, F_NONE, 0, -1);
        send_pkt(16'd1, 256, 1'b1, F_NONE, 0, 2);
        do_reset(2);
        check_counters("mid_rst");
        send_pkt(16'd0, 256, 1'b1, F_NONE, 0, -1);
        send_pkt(16'd1, 64, 1'b1, F_NONE, 0, -1);
        check_counters("after_rst");
        check("after_rst_err0", err_pkt_cnt, 0);

        // randomized traffic with mixed faults, gaps and drops
        do_reset(2);
        for (int n = 0; n < 150; n++) begin
            sz = $urandom_range(4, 600);
            nb = (sz + 63) / 64;
            r = $urandom % 10;
            case (r)
                5: flt = F_SIZE;
                6: flt = F_TUSER;
                7: flt = (nb >= 2) ? F_MIDKEEP : F_NONE;
                8: flt = F_PAY0;
                9: flt = F_LASTSHIFT;
                default: flt = F_NONE;
            endcase
            sq = (($urandom % 10) == 0) ? m_exp_seq + 16'($urandom_range(1, 5)) : m_exp_seq;
            en = (($urandom % 100) < 85);
            send_pkt(sq, sz, en, flt, 20, -1);
            check_counters("rnd");
        end
        tick();
        check("rnd_pulses", pulse_cnt, m_err);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cmac_rx_pkt_checker.md
# cmac_rx_pkt_checker

Receive-side checker for the CMAC loopback performance test: consumes the 512-bit AXI-Stream leaving the receiving CMAC wrapper, checks each packet's length, sequence number and payload pattern against the transmit generator's format, and keeps packet, error and throughput counters. It sits in the single user clock domain between the RX CMAC wrapper and the debug probes, and is the receiving end of the UDP/CMAC packet generator.

## Interface
- DATA_WIDTH, 512, tdata width (multiple of 32)
- KEEP_WIDTH, 64, DATA_WIDTH/8
- CNT_WIDTH, 32, width of all counters
- CLK  in  1  user clock; all logic rising-edge
- RST_N  in  1  asynchronous, active-low reset
- rx_axis_tvalid / tready  in / out  1  AXIS handshake
- rx_axis_tdata  in  DATA_WIDTH  payload
- rx_axis_tkeep  in  KEEP_WIDTH  byte enables
- rx_axis_tlast  in  1  end of packet
- rx_axis_tuser  in  1  CMAC error flag
- recv_en  in  1  count/check enable, sampled at first beat of a packet
- pkt_size  in  16  expected packet length in bytes (1..65535)
- recv_pkt_cnt, err_pkt_cnt, total_beat_cnt, perf_beat_cnt, perf_cycle_cnt  out  CNT_WIDTH  counters
- perf_cycle_full  out  1  perf_cycle_cnt saturated
- first_pkt_seen  out  1  a packet has been accepted since reset
- err_pulse  out  1  one-cycle pulse per errored packet

## Operation
- Beat accepted when tvalid & tready. tready is 0 in reset, 1 from the first cycle after RST_N deasserts; never backpressures.
- Payload format: 32-bit lane k of beat b of packet p = {p[15:0], b[11:0], k[3:0]}.
- FSM states: IDLE, RECV, DROP. IDLE: first accepted beat -> RECV if recv_en else DROP (single-beat packet with tlast evaluated in the same cycle, stays IDLE). RECV/DROP: accepted beat with tlast -> IDLE.
- DROP: beats discarded; no counter, sequence or error update.
- RECV per beat: byte count += popcount(tkeep); beat index b increments; sequence field of lane 0 on beat 0 latched as received seq.
- Packet error if any: byte count ≠ pkt_size; tuser=1 on any beat; non-last beat tkeep not all ones; last beat tkeep not contiguous from bit 0; received seq ≠ expected seq; payload mismatch (see Configuration). Beat index wraps at 4096, matching 12-bit field.
- Expected seq: 0 after reset; after each checked packet becomes received seq + 1 (resync on mismatch), mod 2^16.
- At packet end: recv_pkt_cnt += 1; if error, err_pkt_cnt += 1 and err_pulse.
- total_beat_cnt: every accepted beat in RECV (incl. first beat), wraps.
- Perf window opens on first RECV beat after reset: perf_cycle_cnt counts every cycle thereafter, perf_beat_cnt counts RECV beats; both stop (freeze) when perf_cycle_cnt reaches all ones, perf_cycle_full = 1.
- Counters other than perf pair wrap at 2^CNT_WIDTH.

## Timing
- All outputs registered; reset value 0 for every output including tready.
- Counter and err_pulse updates visible the cycle after the tlast handshake.
- first_pkt_seen rises the cycle after first RECV beat; perf_cycle_cnt = 1 in that cycle.
- pkt_size sampled at tlast beat; changing mid-packet is legal, last value wins.
- recv_en change mid-packet has no effect on that packet.
- Reset mid-packet: FSM returns to IDLE, partial packet lost, all counters cleared; next beat treated as a first beat.
- Back-to-back packets (tlast then new beat next cycle) supported at full rate.

## Configuration
- PKT_CHECK_PAYLOAD_EN defined: every enabled 32-bit lane (full tkeep nibble) compared to the pattern; any mismatch flags the packet.
- Not defined: lanes are not compared (only lane 0 beat 0 seq field used); length, tkeep, tuser and sequence checks remain.

## Test plan
- recv_en=1, pkt_size=256, seq 0..9 correct 4-beat packets back-to-back -> recv_pkt_cnt=10, err_pkt_cnt=0, total_beat_cnt=40, perf_beat_cnt=40.
- pkt_size=100, packet of 2 beats with last tkeep=0x0000_000F_FFFF_FFFF -> no error; same with last tkeep=0xF0 -> err_pkt_cnt=1, err_pulse once.
- Sequence 0,1,5,6 -> err_pkt_cnt=1 (packet 5 only), no error on 6.
- With PKT_CHECK_PAYLOAD_EN, flip one bit in lane 7 beat 1 -> err_pkt_cnt=1; without macro -> err_pkt_cnt=0.
- recv_en=0 for 3 packets, then 1 -> those packets uncounted, first_pkt_seen rises only on fourth; tuser=1 on one beat -> error.
- Assert RST_N low mid-packet for 2 cycles, resend from seq 0 -> all counters restart at 0, no spurious error.
